// File: rtl/sad_me_pkg.sv
// Shared definitions for the motion-estimation SAD consumer stage.
// Holds the search geometry, SAD / MV widths, FSM state encoding and the
// all-ones SAD value used as the "no candidate yet" starting minimum.
package sad_me_pkg;

  localparam int SRCH_R   = 8;                              // +/- search range
  localparam int SAD_W    = 16;                             // SAD width from upstream
  localparam int MV_W     = 5;                              // signed MV component width
  localparam int NUM_CAND = (2 * SRCH_R + 1) * (2 * SRCH_R + 1);

  localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mv_raster_cnt.sv
// Raster-order candidate position counter for the MV search window.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   synchronous active-low reset, returns to (-R,-R)
//   init  in   reload (-R,-R); has priority over adv
//   adv   in   step to next candidate, x fastest
//   cx    out  signed x of current candidate
//   cy    out  signed y of current candidate
//   last  out  current candidate is (+R,+R)
module mv_raster_cnt #(
  parameter int SRCH_R = 8,
  parameter int MV_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init,
  input  logic                   adv,
  output logic signed [MV_W-1:0] cx,
  output logic signed [MV_W-1:0] cy,
  output logic                   last
);

  localparam logic signed [MV_W-1:0] POS_R = MV_W'(SRCH_R);
  localparam logic signed [MV_W-1:0] NEG_R = -POS_R;
  localparam logic signed [MV_W-1:0] ONE   = MV_W'(1);

  logic signed [MV_W-1:0] cx_r;
  logic signed [MV_W-1:0] cy_r;
  logic signed [MV_W-1:0] cx_nx_s;
  logic signed [MV_W-1:0] cy_nx_s;

  // Next-position logic: x wraps to -R at +R and carries into y; y also wraps
  // so the counter never leaves the window even if advanced past the end.
  always_comb begin
    cx_nx_s = cx_r;
    cy_nx_s = cy_r;
    if (init) begin
      cx_nx_s = NEG_R;
      cy_nx_s = NEG_R;
    end else if (adv) begin
      if (cx_r == POS_R) begin
        cx_nx_s = NEG_R;
        if (cy_r == POS_R) begin
          cy_nx_s = NEG_R;
        end else begin
          cy_nx_s = cy_r + ONE;
        end
      end else begin
        cx_nx_s = cx_r + ONE;
        cy_nx_s = cy_r;
      end
    end else begin
      cx_nx_s = cx_r;
      cy_nx_s = cy_r;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx_r <= NEG_R;
      cy_r <= NEG_R;
    end else begin
      cx_r <= cx_nx_s;
      cy_r <= cy_nx_s;
    end
  end

  assign cx   = cx_r;
  assign cy   = cy_r;
  assign last = (cx_r == POS_R) && (cy_r == POS_R);

endmodule

// File: rtl/sad_best_mv_search.sv
// Best-match search over a stream of candidate SADs in raster order.
// Tracks the strict running minimum and the MV where it first occurred,
// optionally stopping early once a SAD at or below a latched threshold shows up.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   srch_start in   1-cycle pulse starting (or restarting) a search
//   ethr_en    in   early-termination enable, latched with srch_start
//   ethr       in   early-termination threshold, latched with srch_start
//   sad        in   candidate SAD
//   sad_vld    in   sad valid, one candidate per pulse
//   busy       out  high while searching
//   done       out  1-cycle pulse when best_* are final
//   best_sad   out  minimum SAD seen
//   best_mvx   out  signed x of the minimum
//   best_mvy   out  signed y of the minimum
//   early_term out  last search ended on the threshold
//   orphan_err out  sticky: sad_vld seen outside a search
module sad_best_mv_search
  import sad_me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srch_start,
  input  logic             ethr_en,
  input  logic [SAD_W-1:0] ethr,
  input  logic [SAD_W-1:0] sad,
  input  logic             sad_vld,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_mvx,
  output logic [MV_W-1:0]  best_mvy,
  output logic             early_term,
  output logic             orphan_err
);

  localparam logic signed [MV_W-1:0] NEG_R = -(MV_W'(SRCH_R));

  state_t                 state_r;
  state_t                 state_nx_s;
  logic                   busy_r;
  logic                   done_r;
  logic                   ethr_en_r;
  logic [SAD_W-1:0]       ethr_r;
  logic [SAD_W-1:0]       best_sad_r;
  logic [MV_W-1:0]        best_mvx_r;
  logic [MV_W-1:0]        best_mvy_r;
  logic                   early_term_r;
  logic                   orphan_err_r;

  logic signed [MV_W-1:0] cx_s;
  logic signed [MV_W-1:0] cy_s;
  logic                   cnt_last_s;
  logic                   accept_s;
  logic                   better_s;
  logic                   thr_hit_s;
  logic                   fin_s;

  mv_raster_cnt #(
    .SRCH_R (SRCH_R),
    .MV_W   (MV_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (srch_start),
    .adv    (accept_s),
    .cx     (cx_s),
    .cy     (cy_s),
    .last   (cnt_last_s)
  );

  // Candidate qualification and next-state; a start pulse overrides every
  // state and swallows any sad presented in the same cycle.
  always_comb begin
    accept_s   = 1'b0;
    better_s   = 1'b0;
    thr_hit_s  = 1'b0;
    fin_s      = 1'b0;
    state_nx_s = state_r;

    accept_s  = (state_r == ST_SEARCH) && sad_vld && !srch_start;
    better_s  = (sad < best_sad_r);
    thr_hit_s = ethr_en_r && (sad <= ethr_r);
    fin_s     = accept_s && (cnt_last_s || thr_hit_s);

    if (srch_start) begin
      state_nx_s = ST_SEARCH;
    end else begin
      case (state_r)
        ST_IDLE:   state_nx_s = ST_IDLE;
        ST_SEARCH: state_nx_s = fin_s ? ST_DONE : ST_SEARCH;
        ST_DONE:   state_nx_s = ST_IDLE;
        default:   state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State, registered status outputs, running minimum and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      ethr_en_r    <= 1'b0;
      ethr_r       <= {SAD_W{1'b0}};
      best_sad_r   <= SAD_MAX;
      best_mvx_r   <= {MV_W{1'b0}};
      best_mvy_r   <= {MV_W{1'b0}};
      early_term_r <= 1'b0;
      orphan_err_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == ST_SEARCH);
      done_r  <= (state_nx_s == ST_DONE);
      if (srch_start) begin
        ethr_en_r    <= ethr_en;
        ethr_r       <= ethr;
        best_sad_r   <= SAD_MAX;
        // An all-max search never improves, so it reports the first candidate.
        best_mvx_r   <= NEG_R;
        best_mvy_r   <= NEG_R;
        early_term_r <= 1'b0;
        orphan_err_r <= 1'b0;
      end else begin
        // Strict compare keeps the earliest candidate on ties.
        if (accept_s && better_s) begin
          best_sad_r <= sad;
          best_mvx_r <= cx_s;
          best_mvy_r <= cy_s;
        end
        if (accept_s && thr_hit_s) begin
          early_term_r <= 1'b1;
        end
        if (sad_vld && (state_r != ST_SEARCH)) begin
          orphan_err_r <= 1'b1;
        end
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign best_sad   = best_sad_r;
  assign best_mvx   = best_mvx_r;
  assign best_mvy   = best_mvy_r;
  assign early_term = early_term_r;
  assign orphan_err = orphan_err_r;

endmodule

// File: tb/tb_sad_best_mv_search.sv
// Self-checking bench for sad_best_mv_search: directed vector table,
// hand-written restart / orphan / reset sequences and randomized searches
// checked against an array-walking reference model.
module tb_sad_best_mv_search;
  import sad_me_pkg::*;

  localparam int N = 2 * SRCH_R + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             srch_start = 1'b0;
  logic             ethr_en = 1'b0;
  logic [SAD_W-1:0] ethr = '0;
  logic [SAD_W-1:0] sad = '0;
  logic             sad_vld = 1'b0;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [MV_W-1:0]  best_mvx;
  logic [MV_W-1:0]  best_mvy;
  logic             early_term;
  logic             orphan_err;

  int checks = 0;
  int errors = 0;

  logic [SAD_W-1:0] cand [NUM_CAND];

  typedef struct {
    int fill;
    int k1;
    int v1;
    int k2;
    int v2;
    bit een;
    int thr;
    int exp_sad;
    int exp_x;
    int exp_y;
    bit exp_et;
    int exp_last;
  } vec_t;

  vec_t vecs [7];

  sad_best_mv_search dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .srch_start (srch_start),
    .ethr_en    (ethr_en),
    .ethr       (ethr),
    .sad        (sad),
    .sad_vld    (sad_vld),
    .busy       (busy),
    .done       (done),
    .best_sad   (best_sad),
    .best_mvx   (best_mvx),
    .best_mvy   (best_mvy),
    .early_term (early_term),
    .orphan_err (orphan_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the candidate list, strict minimum, stop at threshold or end.
  function automatic void model(input bit een, input int thr, output int bs, output int bx,
                                output int by, output int lastk, output bit et);
    bs = 65535; bx = -SRCH_R; by = -SRCH_R; lastk = NUM_CAND - 1; et = 1'b0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (int'(cand[k]) < bs) begin
        bs = int'(cand[k]);
        bx = k % N - SRCH_R;
        by = k / N - SRCH_R;
      end
      if (een && int'(cand[k]) <= thr) begin
        lastk = k;
        et = 1'b1;
        break;
      end
    end
  endfunction

  task automatic run_search(input bit do_start, input bit een, input int thr, input bit gaps,
                            input int exp_sad, input int exp_x, input int exp_y,
                            input bit exp_et, input int exp_last);
    if (do_start) begin
      srch_start = 1'b1;
      ethr_en = een;
      ethr = SAD_W'(thr);
      step();
      srch_start = 1'b0;
      ethr_en = 1'b0;
      ethr = '0;
      chk("busy_after_start", busy, 1);
      chk("orphan_cleared", orphan_err, 0);
    end
    for (int k = 0; k <= exp_last; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        sad = SAD_W'($urandom);
        step();
      end
      sad = cand[k];
      sad_vld = 1'b1;
      step();
      sad_vld = 1'b0;
      chk("done_timing", done, (k == exp_last) ? 1 : 0);
    end
    chk("best_sad", best_sad, exp_sad);
    chk("best_mvx", $signed(best_mvx), exp_x);
    chk("best_mvy", $signed(best_mvy), exp_y);
    chk("early_term", early_term, exp_et);
    chk("busy_at_done", busy, 0);
    chk("orphan_none", orphan_err, 0);
    step();
    chk("done_one_cycle", done, 0);
    chk("best_sad_hold", best_sad, exp_sad);
    chk("early_term_hold", early_term, exp_et);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_best_sad"}, best_sad, 65535);
    chk({tag, "_mvx"}, $signed(best_mvx), 0);
    chk({tag, "_mvy"}, $signed(best_mvy), 0);
    chk({tag, "_early"}, early_term, 0);
    chk({tag, "_orphan"}, orphan_err, 0);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int k = 0; k < NUM_CAND; k++) cand[k] = SAD_W'($urandom_range(hi, lo));
  endtask

  initial begin
    int bs, bx, by, lk;
    bit et;
    int pbs, pbx, pby;

    //            fill   k1  v1  k2  v2  een thr  sad  x   y  et last
    vecs[0] = '{1000, 150, 37, -1, 0, 1'b0, 0, 37, 6, 0, 1'b0, 288};
    vecs[1] = '{900, 20, 5, 200, 5, 1'b0, 0, 5, -5, -7, 1'b0, 288};
    vecs[2] = '{1000, 10, 49, -1, 0, 1'b1, 50, 49, 2, -8, 1'b1, 10};
    vecs[3] = '{65535, -1, 0, -1, 0, 1'b0, 0, 65535, -8, -8, 1'b0, 288};
    vecs[4] = '{500, 288, 499, -1, 0, 1'b0, 0, 499, 8, 8, 1'b0, 288};
    vecs[5] = '{1000, 3, 51, 5, 50, 1'b1, 50, 50, -3, -8, 1'b1, 5};
    vecs[6] = '{1000, 7, 0, -1, 0, 1'b0, 100, 0, -1, -8, 1'b0, 288};

    rst_n = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();
    chk("idle_done", done, 0);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < NUM_CAND; k++) cand[k] = SAD_W'(vecs[i].fill);
      if (vecs[i].k1 >= 0) cand[vecs[i].k1] = SAD_W'(vecs[i].v1);
      if (vecs[i].k2 >= 0) cand[vecs[i].k2] = SAD_W'(vecs[i].v2);
      run_search(1'b1, vecs[i].een, vecs[i].thr, (i % 2) == 1, vecs[i].exp_sad,
                 vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_et, vecs[i].exp_last);
    end

    // Orphan: sad_vld while idle flags an error and leaves best_* alone.
    pbs = int'(best_sad);
    pbx = int'($signed(best_mvx));
    pby = int'($signed(best_mvy));
    sad = '0;
    sad_vld = 1'b1;
    step();
    sad_vld = 1'b0;
    chk("orphan_set", orphan_err, 1);
    chk("orphan_best_sad", best_sad, pbs);
    chk("orphan_mvx", $signed(best_mvx), pbx);
    chk("orphan_mvy", $signed(best_mvy), pby);
    chk("orphan_no_done", done, 0);
    step();
    chk("orphan_sticky", orphan_err, 1);
    fill_random(100, 60000);
    model(1'b0, 0, bs, bx, by, lk, et);
    run_search(1'b1, 1'b0, 0, 1'b0, bs, bx, by, et, lk);

    // Restart at k=100 with a concurrent sad that must be dropped.
    fill_random(300, 60000);
    srch_start = 1'b1;
    step();
    srch_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      sad = cand[k];
      sad_vld = 1'b1;
      step();
      sad_vld = 1'b0;
      chk("restart_pre_done", done, 0);
    end
    srch_start = 1'b1;
    ethr_en = 1'b0;
    sad = '0;
    sad_vld = 1'b1;
    step();
    srch_start = 1'b0;
    sad_vld = 1'b0;
    chk("restart_no_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_best_init", best_sad, 65535);
    fill_random(200, 60000);
    model(1'b0, 0, bs, bx, by, lk, et);
    run_search(1'b0, 1'b0, 0, 1'b1, bs, bx, by, et, lk);

    // Reset mid-search at k=120.
    fill_random(0, 65535);
    srch_start = 1'b1;
    step();
    srch_start = 1'b0;
    for (int k = 0; k < 120; k++) begin
      sad = cand[k];
      sad_vld = 1'b1;
      step();
      sad_vld = 1'b0;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_vals("midreset");
    step();
    chk("midreset_no_done", done, 0);
    fill_random(0, 65535);
    model(1'b0, 0, bs, bx, by, lk, et);
    run_search(1'b1, 1'b0, 0, 1'b0, bs, bx, by, et, lk);

    // Randomized searches against the model.
    for (int r = 0; r < 8; r++) begin
      bit een;
      int thr;
      if (r % 2 == 0) fill_random(0, 2000);
      else fill_random(0, 65535);
      een = 1'($urandom_range(0, 1));
      thr = (r % 2 == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 800));
      model(een, thr, bs, bx, by, lk, et);
      run_search(1'b1, een, thr, 1'b1, bs, bx, by, et, lk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
